// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit frame controller sitting in front of the data
// serializer. Latches a byte and its parity settings on a Data_Valid request
// while idle, then sequences START -> DATA -> (PARITY) -> STOP.
// It drives the serializer enable and muxes the UART line; the line idles high.
//
// Build option: define UART_TX_B2B_EN to accept a new request during the STOP
// cycle, so back-to-back frames have no idle gap. In the default build STOP
// always returns to IDLE.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | line high, waiting for Data_Valid
//   START  | start bit (low); serializer loads the latched byte
//   DATA   | serializer bits on the line, LSB first, until ser_done
//   PARITY | parity bit from the parity register (only if PAR_EN latched)
//   STOP   | stop bit (high); may accept the next frame with B2B option
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_data,
    input  logic                  ser_done,
    output logic [DATA_WIDTH-1:0] ser_p_data,
    output logic                  ser_en,
    output logic                  TX_OUT,
    output logic                  busy
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_q, par_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  accept;

    // Request acceptance: idle always, STOP too when back-to-back is built in.
    always_comb begin
`ifdef UART_TX_B2B_EN
        accept = Data_Valid && ((state_q == ST_IDLE) || (state_q == ST_STOP));
`else
        accept = Data_Valid && (state_q == ST_IDLE);
`endif
    end

    // Next-state and frame-register logic.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        // The parity register is kept equal to the parity of the latched byte
        // and type, so it can never disagree with what the serializer sends.
        par_d     = (^data_q) ^ par_typ_q;

        if (accept) begin
            data_d    = P_DATA;
            par_en_d  = PAR_EN;
            par_typ_d = PAR_TYP;
            par_d     = (^P_DATA) ^ PAR_TYP;
            state_d   = ST_START;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = ST_IDLE;
                ST_START:  state_d = ST_DATA;
                ST_DATA: begin
                    if (ser_done) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: state_d = ST_STOP;
                ST_STOP:   state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // State and frame registers; reset abandons any frame in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            par_q     <= 1'b0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            par_q     <= par_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
        end
    end

    // Output decode from registered state only, so reset forces the line high
    // without waiting for a clock edge.
    always_comb begin
        TX_OUT = 1'b1;
        case (state_q)
            ST_IDLE:   TX_OUT = 1'b1;
            ST_START:  TX_OUT = 1'b0;
            ST_DATA:   TX_OUT = ser_data;
            ST_PARITY: TX_OUT = par_q;
            ST_STOP:   TX_OUT = 1'b1;
            default:   TX_OUT = 1'b1;
        endcase
    end

    // ser_en drops in the last data-bit cycle so the serializer does not reload.
    always_comb begin
        ser_en = (state_q == ST_START) || ((state_q == ST_DATA) && !ser_done);
        busy   = (state_q != ST_IDLE);
    end

    assign ser_p_data = data_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed testbench for uart_tx_ctrl with a small behavioural serializer.
module tb_uart_tx_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       ser_data;
    logic       ser_done;
    logic [7:0] ser_p_data;
    logic       ser_en;
    logic       TX_OUT;
    logic       busy;

    int checks;
    int passed;

    logic       cap_tx   [0:31];
    logic       cap_busy [0:31];
    logic       cap_en   [0:31];
    logic [7:0] cap_pd   [0:31];

    uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .ser_data   (ser_data),
        .ser_done   (ser_done),
        .ser_p_data (ser_p_data),
        .ser_en     (ser_en),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serializer model: loads on the first enabled edge, shifts on enabled
    // edges, flags bit 7 with ser_done and then releases.
    logic       s_active;
    logic [2:0] s_idx;
    logic [7:0] s_reg;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_active <= 1'b0;
            s_idx    <= 3'd0;
            s_reg    <= 8'h00;
        end else if (!s_active && ser_en) begin
            s_active <= 1'b1;
            s_idx    <= 3'd0;
            s_reg    <= ser_p_data;
        end else if (s_active) begin
            if (s_idx == 3'd7) s_active <= 1'b0;
            else if (ser_en)   s_idx <= s_idx + 3'd1;
        end
    end

    assign ser_done = s_active && (s_idx == 3'd7);
    assign ser_data = s_active ? s_reg[s_idx] : 1'b0;

    // Raise a request at a falling edge; it is accepted on the next rising edge.
    task automatic start_frame(input logic [7:0] d, input logic pe, input logic pt);
        @(negedge clk);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Data_Valid = 1'b1;
    endtask

    // Sample n cycles at falling edges. Data_Valid drops after sample drop_at;
    // at sample inj_at an intruding 0xFF request is pulsed for one cycle;
    // if drop_at > 0 the byte switches to next_data after sample 0.
    task automatic capture(input int n, input int drop_at, input int inj_at,
                           input logic [7:0] next_data);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cap_tx[i]   = TX_OUT;
            cap_busy[i] = busy;
            cap_en[i]   = ser_en;
            cap_pd[i]   = ser_p_data;
            if (i == 0 && drop_at > 0) P_DATA = next_data;
            if (i == drop_at) Data_Valid = 1'b0;
            if (i == inj_at) begin
                P_DATA     = 8'hFF;
                Data_Valid = 1'b1;
            end
            if (inj_at >= 0 && i == inj_at + 1) Data_Valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (TX_OUT !== 1'b1) $display("FAIL reset_tx: got %b want 1", TX_OUT); else passed++;
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        checks++;
        if (ser_en !== 1'b0) $display("FAIL reset_ser_en: got %b want 0", ser_en); else passed++;
        checks++;
        if (ser_p_data !== 8'h00) $display("FAIL reset_pdata: got %h want 00", ser_p_data); else passed++;

        // Abort a frame in DATA with an asynchronous reset away from any edge.
        start_frame(8'h00, 1'b1, 1'b0);
        capture(4, 0, -1, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (TX_OUT !== 1'b1) $display("FAIL midreset_tx: got %b want 1", TX_OUT); else passed++;
        checks++;
        if (busy !== 1'b0) $display("FAIL midreset_busy: got %b want 0", busy); else passed++;
        checks++;
        if (ser_en !== 1'b0) $display("FAIL midreset_ser_en: got %b want 0", ser_en); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (TX_OUT !== 1'b1 || busy !== 1'b0 || ser_en !== 1'b0)
                $display("FAIL post_reset_idle[%0d]: got tx=%b busy=%b en=%b want 1 0 0",
                         i, TX_OUT, busy, ser_en);
            else passed++;
        end
    endtask

    task automatic test_even_parity();
        logic [0:11] etx;
        etx = 12'b0101001010_11;
        start_frame(8'hA5, 1'b1, 1'b0);
        capture(12, 0, -1, 8'h00);
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (cap_tx[i] !== etx[i] || cap_busy[i] !== (i < 11))
                $display("FAIL even_a5[%0d]: got tx=%b busy=%b want tx=%b busy=%b",
                         i, cap_tx[i], cap_busy[i], etx[i], (i < 11));
            else passed++;
        end
    endtask

    task automatic test_odd_parity();
        logic [0:11] etx;
        etx = 12'b0101001011_11;
        start_frame(8'hA5, 1'b1, 1'b1);
        capture(12, 0, -1, 8'h00);
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (cap_tx[i] !== etx[i] || cap_busy[i] !== (i < 11))
                $display("FAIL odd_a5[%0d]: got tx=%b busy=%b want tx=%b busy=%b",
                         i, cap_tx[i], cap_busy[i], etx[i], (i < 11));
            else passed++;
        end
    endtask

    task automatic test_no_parity();
        logic [0:11] etx;
        etx = 12'b0101001011_11;
        start_frame(8'hA5, 1'b0, 1'b1);
        capture(12, 0, -1, 8'h00);
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (cap_tx[i] !== etx[i] || cap_busy[i] !== (i < 10))
                $display("FAIL nopar_a5[%0d]: got tx=%b busy=%b want tx=%b busy=%b",
                         i, cap_tx[i], cap_busy[i], etx[i], (i < 10));
            else passed++;
        end
    endtask

    task automatic test_input_stability();
        logic [0:12] etx;
        etx = 13'b01000000011_11;
        start_frame(8'h01, 1'b1, 1'b0);
        capture(13, 0, 3, 8'h00);
        for (int i = 0; i < 13; i++) begin
            checks++;
            if (cap_tx[i] !== etx[i] || cap_busy[i] !== (i < 11) || cap_pd[i] !== 8'h01)
                $display("FAIL stability_01[%0d]: got tx=%b busy=%b pd=%h want tx=%b busy=%b pd=01",
                         i, cap_tx[i], cap_busy[i], cap_pd[i], etx[i], (i < 11));
            else passed++;
        end
    endtask

    task automatic test_handshake();
        start_frame(8'h01, 1'b1, 1'b0);
        capture(12, 0, -1, 8'h00);
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (cap_en[i] !== (i < 8))
                $display("FAIL handshake_ser_en[%0d]: got %b want %b", i, cap_en[i], (i < 8));
            else passed++;
        end
        checks++;
        if (cap_tx[9] !== 1'b1) $display("FAIL handshake_parity: got %b want 1", cap_tx[9]);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [0:20] etx;
        logic        ebusy;
        logic [7:0]  epd;
`ifdef UART_TX_B2B_EN
        etx = 21'b0001111001_0110000111_1;
`else
        etx = 21'b0001111001_1_0110000111;
`endif
        start_frame(8'h3C, 1'b0, 1'b0);
        capture(21, 11, -1, 8'hC3);
        for (int i = 0; i < 21; i++) begin
`ifdef UART_TX_B2B_EN
            ebusy = (i < 20);
            epd   = (i < 10) ? 8'h3C : 8'hC3;
`else
            ebusy = (i != 10);
            epd   = (i < 11) ? 8'h3C : 8'hC3;
`endif
            checks++;
            if (cap_tx[i] !== etx[i] || cap_busy[i] !== ebusy || cap_pd[i] !== epd)
                $display("FAIL b2b[%0d]: got tx=%b busy=%b pd=%h want tx=%b busy=%b pd=%h",
                         i, cap_tx[i], cap_busy[i], cap_pd[i], etx[i], ebusy, epd);
            else passed++;
        end
    endtask

    initial begin
        checks     = 0;
        passed     = 0;
        rst_n      = 1'b0;
        P_DATA     = 8'h00;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_even_parity();
        test_odd_parity();
        test_no_parity();
        test_input_stability();
        test_handshake();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
